regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (WriteRegister/WriteData/RegWrite) between two writeback requesters, A (ALU) and B (memory).
- Each requester uses a valid/ready handshake. Contention is resolved by round-robin.
- Includes a clear sequencer that zeroes registers 1..NUM_REGS-1 on command.
- Sits between the writeback stages and the regfile. Its outputs drive the regfile write port directly, and the regfile commits on the next posedge Clk.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 19 +
 rtl/regfile_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared regfile write-arbiter constants, FSM state encoding and grant encoding.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant, purely combinational; grants are one-hot or zero.
// On contention the requester that did not win last time is granted.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic i_vld_a,
   input  logic i_vld_b,
   input  logic i_last_grant,
   output logic o_grant_a,
   output logic o_grant_b
);

   logic w_prefer_a;

   assign w_prefer_a = (i_last_grant == GRANT_B);
   assign o_grant_a  = i_vld_a && (!i_vld_b || w_prefer_a);
   assign o_grant_b  = i_vld_b && (!i_vld_a || !w_prefer_a);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the regfile write port between A and B, plus a clear walk of regs 1..NUM_REGS-1.
// Accept at edge N drives RegWrite in cycle N..N+1; optional REGWRITE_FWD_EN adds read-port forwarding.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  ReqValidA,
   input  logic [ADDR_WIDTH-1:0] ReqRegisterA,
   input  logic [DATA_WIDTH-1:0] ReqDataA,
   output logic                  ReqReadyA,
   input  logic                  ReqValidB,
   input  logic [ADDR_WIDTH-1:0] ReqRegisterB,
   input  logic [DATA_WIDTH-1:0] ReqDataB,
   output logic                  ReqReadyB,
   input  logic                  Clear,
   output logic                  Busy,
   output logic [ADDR_WIDTH-1:0] WriteRegister,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  RegWrite
`ifdef REGWRITE_FWD_EN
   ,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   input  logic [DATA_WIDTH-1:0] ReadData1,
   input  logic [DATA_WIDTH-1:0] ReadData2,
   output logic [DATA_WIDTH-1:0] FwdData1,
   output logic [DATA_WIDTH-1:0] FwdData2
`endif
);
   import regfile_pkg::*;

   state_t                r_state;
   grant_t                r_last_grant;
   logic                  r_busy;
   logic                  r_reg_write;
   logic [ADDR_WIDTH-1:0] r_write_register;
   logic [DATA_WIDTH-1:0] r_write_data;

   state_t                w_state_nxt;
   grant_t                w_last_grant_nxt;
   logic                  w_busy_nxt;
   logic                  w_reg_write_nxt;
   logic [ADDR_WIDTH-1:0] w_write_register_nxt;
   logic [DATA_WIDTH-1:0] w_write_data_nxt;
   logic                  w_grant_a;
   logic                  w_grant_b;
   logic                  w_ready_a;
   logic                  w_ready_b;

   rr_arbiter2 u_rr_arbiter2 (
      .i_vld_a      (ReqValidA),
      .i_vld_b      (ReqValidB),
      .i_last_grant (r_last_grant),
      .o_grant_a    (w_grant_a),
      .o_grant_b    (w_grant_b)
   );

   always_comb begin
      w_state_nxt          = r_state;
      w_last_grant_nxt     = r_last_grant;
      w_busy_nxt           = r_busy;
      w_reg_write_nxt      = 1'b0;
      w_write_register_nxt = r_write_register;
      w_write_data_nxt     = r_write_data;
      w_ready_a            = 1'b0;
      w_ready_b            = 1'b0;
      case (r_state)
         IDLE: begin
            if (Clear) begin
               w_state_nxt          = CLEAR;
               w_busy_nxt           = 1'b1;
               w_write_register_nxt = ADDR_WIDTH'(1);
               w_write_data_nxt     = '0;
               w_reg_write_nxt      = 1'b1;
            end else begin
               w_ready_a = w_grant_a;
               w_ready_b = w_grant_b;
               // Register 0 is hardwired: the write is consumed but never reaches the regfile.
               if (w_grant_a) begin
                  w_write_register_nxt = ReqRegisterA;
                  w_write_data_nxt     = ReqDataA;
                  w_last_grant_nxt     = GRANT_A;
                  w_reg_write_nxt      = (ReqRegisterA != '0);
               end else if (w_grant_b) begin
                  w_write_register_nxt = ReqRegisterB;
                  w_write_data_nxt     = ReqDataB;
                  w_last_grant_nxt     = GRANT_B;
                  w_reg_write_nxt      = (ReqRegisterB != '0);
               end
            end
         end
         CLEAR: begin
            if (r_write_register == ADDR_WIDTH'(NUM_REGS - 1)) begin
               w_state_nxt     = IDLE;
               w_busy_nxt      = 1'b0;
               w_reg_write_nxt = 1'b0;
            end else begin
               w_write_register_nxt = r_write_register + ADDR_WIDTH'(1);
               w_write_data_nxt     = '0;
               w_reg_write_nxt      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state          <= IDLE;
         r_last_grant     <= GRANT_B;
         r_busy           <= 1'b0;
         r_reg_write      <= 1'b0;
         r_write_register <= '0;
         r_write_data     <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_last_grant     <= w_last_grant_nxt;
         r_busy           <= w_busy_nxt;
         r_reg_write      <= w_reg_write_nxt;
         r_write_register <= w_write_register_nxt;
         r_write_data     <= w_write_data_nxt;
      end
   end

   assign ReqReadyA     = w_ready_a;
   assign ReqReadyB     = w_ready_b;
   assign Busy          = r_busy;
   assign RegWrite      = r_reg_write;
   assign WriteRegister = r_write_register;
   assign WriteData     = r_write_data;

`ifdef REGWRITE_FWD_EN
   // Covers the cycle where the regfile has not yet committed the pending write.
   assign FwdData1 = (r_reg_write && (r_write_register == ReadRegister1) && (ReadRegister1 != '0))
                     ? r_write_data : ReadData1;
   assign FwdData2 = (r_reg_write && (r_write_register == ReadRegister2) && (ReadRegister2 != '0))
                     ? r_write_data : ReadData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: scoreboard of expected regfile writes plus a small regfile model.
// Forwarding checks are compiled in only when REGWRITE_FWD_EN is defined.
module tb_regfile_write_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 32;

   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          ReqValidA = 1'b0;
   logic [AW-1:0] ReqRegisterA = '0;
   logic [DW-1:0] ReqDataA = '0;
   logic          ReqReadyA;
   logic          ReqValidB = 1'b0;
   logic [AW-1:0] ReqRegisterB = '0;
   logic [DW-1:0] ReqDataB = '0;
   logic          ReqReadyB;
   logic          Clear = 1'b0;
   logic          Busy;
   logic [AW-1:0] WriteRegister;
   logic [DW-1:0] WriteData;
   logic          RegWrite;
`ifdef REGWRITE_FWD_EN
   logic [AW-1:0] ReadRegister1 = '0;
   logic [AW-1:0] ReadRegister2 = '0;
   logic [DW-1:0] ReadData1 = '0;
   logic [DW-1:0] ReadData2 = '0;
   logic [DW-1:0] FwdData1;
   logic [DW-1:0] FwdData2;
`endif

   wr_t           sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] rf [0:NR-1];
   logic          rf_init = 1'b0;

   always #5 Clk = ~Clk;

   regfile_write_arbiter dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .ReqValidA     (ReqValidA),
      .ReqRegisterA  (ReqRegisterA),
      .ReqDataA      (ReqDataA),
      .ReqReadyA     (ReqReadyA),
      .ReqValidB     (ReqValidB),
      .ReqRegisterB  (ReqRegisterB),
      .ReqDataB      (ReqDataB),
      .ReqReadyB     (ReqReadyB),
      .Clear         (Clear),
      .Busy          (Busy),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite)
`ifdef REGWRITE_FWD_EN
      ,
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .FwdData1      (FwdData1),
      .FwdData2      (FwdData2)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wr_t e;
      e.r = r;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Regfile model: every register starts at its own index, reg 0 never written.
   always @(posedge Clk) begin
      if (!rf_init) begin
         for (int i = 0; i < NR; i++) rf[i] <= DW'(i);
         rf_init <= 1'b1;
      end else if (RegWrite === 1'b1 && WriteRegister != '0) begin
         rf[WriteRegister] <= WriteData;
      end
   end

   always @(negedge Clk) begin
      if (RegWrite === 1'b1) begin
         wr_t e;
         chk("sb_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_reg", 64'(WriteRegister), 64'(e.r));
            chk("sb_data", 64'(WriteData), 64'(e.d));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_wreg", WriteRegister, 0);
      chk("rst_wdata", WriteData, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_ready_a", ReqReadyA, 0);
      Reset = 1'b0;

      // both valid and held: A first after reset, then strict alternation
      ReqValidA = 1'b1; ReqRegisterA = 5'd4; ReqDataA = 32'd15;
      ReqValidB = 1'b1; ReqRegisterB = 5'd5; ReqDataB = 32'd16;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         chk("rr_ready_a", ReqReadyA, (i % 2 == 0));
         chk("rr_ready_b", ReqReadyB, (i % 2 == 1));
         if (i % 2 == 0) push(5'd4, 32'd15);
         else            push(5'd5, 32'd16);
         tick;
         chk("rr_regwrite", RegWrite, 1);
         chk("rr_wreg", WriteRegister, (i % 2 == 0) ? 4 : 5);
      end
      ReqValidA = 1'b0;
      ReqValidB = 1'b0;

      // single A write, reg 3 = 42
      ReqValidA = 1'b1; ReqRegisterA = 5'd3; ReqDataA = 32'd42;
      @(negedge Clk);
      chk("a_ready_a", ReqReadyA, 1);
      chk("a_ready_b", ReqReadyB, 0);
      push(5'd3, 32'd42);
      tick;
      ReqValidA = 1'b0;
      chk("a_regwrite", RegWrite, 1);
      chk("a_wreg", WriteRegister, 3);
      chk("a_wdata", WriteData, 42);
      tick;
      chk("a_idle_regwrite", RegWrite, 0);
      chk("a_rf3", rf[3], 42);

      // reg-0 write is accepted and dropped
      ReqValidA = 1'b1; ReqRegisterA = 5'd0; ReqDataA = 32'd18;
      @(negedge Clk);
      chk("r0_ready_a", ReqReadyA, 1);
      tick;
      ReqValidA = 1'b0;
      chk("r0_regwrite", RegWrite, 0);
      chk("r0_wdata", WriteData, 18);
      chk("r0_wreg", WriteRegister, 0);

      // reg 7 = 99, then Clear with B valid in the same cycle
      ReqValidA = 1'b1; ReqRegisterA = 5'd7; ReqDataA = 32'd99;
      @(negedge Clk);
      chk("c_ready_a7", ReqReadyA, 1);
      push(5'd7, 32'd99);
      tick;
      ReqValidA = 1'b0;
      tick;
      chk("c_rf7_pre", rf[7], 99);
      Clear = 1'b1;
      ReqValidB = 1'b1; ReqRegisterB = 5'd9; ReqDataB = 32'd55;
      @(negedge Clk);
      chk("c_ready_b_clear", ReqReadyB, 0);
      chk("c_ready_a_clear", ReqReadyA, 0);
      for (int k = 1; k < NR; k++) push(AW'(k), '0);
      tick;
      Clear = 1'b0;
      for (int k = 1; k < NR; k++) begin
         chk("c_busy", Busy, 1);
         chk("c_wreg", WriteRegister, k);
         chk("c_regwrite", RegWrite, 1);
         chk("c_wdata", WriteData, 0);
         Clear = (k == 5);
         @(negedge Clk);
         chk("c_ready_b_busy", ReqReadyB, 0);
         tick;
      end
      Clear = 1'b0;
      chk("c_busy_end", Busy, 0);
      chk("c_regwrite_end", RegWrite, 0);
      push(5'd9, 32'd55);
      @(negedge Clk);
      chk("c_ready_b_after", ReqReadyB, 1);
      tick;
      ReqValidB = 1'b0;
      chk("c_b_regwrite", RegWrite, 1);
      chk("c_b_wreg", WriteRegister, 9);
      chk("c_rf7_post", rf[7], 0);

      // reset in the middle of a clear walk
      ReqValidA = 1'b1; ReqRegisterA = 5'd20; ReqDataA = 32'd20;
      @(negedge Clk);
      chk("rc_ready_a", ReqReadyA, 1);
      push(5'd20, 32'd20);
      tick;
      ReqValidA = 1'b0;
      tick;
      chk("rc_rf20_pre", rf[20], 20);
      Clear = 1'b1;
      for (int k = 1; k <= 10; k++) push(AW'(k), '0);
      tick;
      Clear = 1'b0;
      repeat (9) tick;
      chk("rc_wreg_step10", WriteRegister, 10);
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      chk("rc_busy", Busy, 0);
      chk("rc_regwrite", RegWrite, 0);
      chk("rc_wreg", WriteRegister, 0);
      tick;
      chk("rc_busy_idle", Busy, 0);
      chk("rc_regwrite_idle", RegWrite, 0);
      chk("rc_rf20_post", rf[20], 20);

`ifdef REGWRITE_FWD_EN
      // forwarding of the in-flight write
      ReadRegister1 = 5'd2; ReadData1 = 32'd7777;
      ReadRegister2 = 5'd3; ReadData2 = 32'd5;
      ReqValidA = 1'b1; ReqRegisterA = 5'd2; ReqDataA = 32'd20;
      push(5'd2, 32'd20);
      tick;
      ReqValidA = 1'b0;
      chk("fwd1_hit", FwdData1, 20);
      chk("fwd2_miss", FwdData2, 5);
      ReadRegister1 = 5'd0;
      #1;
      chk("fwd1_reg0", FwdData1, 7777);
      ReadRegister1 = 5'd2;
      tick;
      chk("fwd1_no_write", FwdData1, 7777);
`endif

      tick;
      tick;
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
